nibble_serial_adder: RTL

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nibble_serial_adder_pkg.sv | 14 +
 rtl/nibble_serial_adder_csa.sv | 30 +++
 rtl/nibble_serial_adder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder.
//   NIBBLE_W : width of one add step (one nibble)
//   state_e  : controller states
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADD     = 2'd1,
    DONE_ST = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_serial_adder_csa.sv
// 4-bit carry-select adder used as the one-nibble datapath step.
// The low two bits ripple; the high two bits are precomputed for both
// possible incoming carries and the low half's carry picks one.
// Ports:
//   A, B  : 4-bit addends
//   Cin   : carry in
//   SUM   : 4-bit sum
//   CARRY : carry out
module nibble_serial_adder_csa (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] SUM,
  output logic       CARRY
);

  logic [2:0] lo;
  logic [2:0] hi_c0;
  logic [2:0] hi_c1;
  logic [2:0] hi_sel;

  assign lo     = {1'b0, A[1:0]} + {1'b0, B[1:0]} + {2'b00, Cin};
  assign hi_c0  = {1'b0, A[3:2]} + {1'b0, B[3:2]};
  assign hi_c1  = {1'b0, A[3:2]} + {1'b0, B[3:2]} + 3'd1;
  assign hi_sel = lo[2] ? hi_c1 : hi_c0;

  assign SUM   = {hi_sel[1:0], lo[1:0]};
  assign CARRY = hi_sel[2];

endmodule

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: adds two WIDTH-bit operands plus a carry-in one
// nibble per clock through a single 4-bit carry-select adder.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   START : begin an addition (sampled only in IDLE)
//   A, B  : WIDTH-bit operands, captured on the accepting edge
//   Cin   : carry into nibble 0, captured with A/B
//   BUSY  : high while nibbles are being added
//   DONE  : one-cycle pulse when SUM/CARRY are valid
//   SUM   : registered WIDTH-bit result, held until the next START
//   CARRY : registered carry out of the top nibble
// WIDTH must be a multiple of 4 and at least 8.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             CARRY
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = $clog2(NIBBLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

  state_e               state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     sum_q, sum_d;
  logic                 carry_q, carry_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 c_reg_q, c_reg_d;
  logic [WIDTH-1:0]     op_a_q, op_a_d;
  logic [WIDTH-1:0]     op_b_q, op_b_d;

  logic [NIBBLE_W-1:0]  nib_a;
  logic [NIBBLE_W-1:0]  nib_b;
  logic [NIBBLE_W-1:0]  csa_sum;
  logic                 csa_carry;

  // Select the operand nibbles addressed by the counter.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    nib_a = '0;
    nib_b = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        nib_a = op_a_q[i*NIBBLE_W +: NIBBLE_W];
        nib_b = op_b_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  nibble_serial_adder_csa csa (
    .A     (nib_a),
    .B     (nib_b),
    .Cin   (c_reg_q),
    .SUM   (csa_sum),
    .CARRY (csa_carry)
  );

  always_comb begin
    state_d = state_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    c_reg_d = c_reg_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;

    unique case (state_q)
      IDLE: begin
        if (START) begin
          op_a_d  = A;
          op_b_d  = B;
          c_reg_d = Cin;
          sum_d   = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ADD;
        end
      end

      ADD: begin
        busy_d  = 1'b1;
        c_reg_d = csa_carry;
        for (int i = 0; i < NIBBLES; i++) begin
          if (cnt_q == CNT_W'(i)) begin
            sum_d[i*NIBBLE_W +: NIBBLE_W] = csa_sum;
          end
        end
        if (cnt_q == CNT_LAST) begin
          // Counter stays on the last nibble so it never wraps.
          carry_d = csa_carry;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE_ST;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE_ST: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: the operand registers are cleared on reset as well, so the
  // datapath never starts from unknown values after rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      c_reg_q <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      c_reg_q <= c_reg_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
    end
  end

  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign SUM   = sum_q;
  assign CARRY = carry_q;

endmodule
